// File: rtl/pzbcm_multi_bits_monitor_pkg.sv
// Shared types and helpers for the multi-bit (non-one-hot) integrity monitor.
`default_nettype none

package pzbcm_multi_bits_monitor_pkg;

    typedef enum logic [1:0] {
        CLEAN     = 2'd0,
        ERROR     = 2'd1,
        SATURATED = 2'd2
    } pzbcm_multi_bits_monitor_state;

    // All-ones value of a COUNT_WIDTH-bit counter (valid up to 63 bits).
    function automatic longint unsigned calc_count_max(input int count_width);
        return (64'd1 << count_width) - 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pzbcm_multi_bits_detector.sv
// Combinational test for "more than one bit set"; optionally also flags an all-zero vector.
`default_nettype none

module pzbcm_multi_bits_detector #(
    parameter int N             = 2,
    parameter bit ZERO_IS_ERROR = 1'b0
) (
    input  logic [N-1:0] i_bits,
    output logic         o_error
);

    logic w_multi;
    logic w_zero;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_multi = |(i_bits & (i_bits - N'(1)));
    assign w_zero  = ~|i_bits;
    assign o_error = w_multi | (ZERO_IS_ERROR & w_zero);

endmodule

`default_nettype wire

// File: rtl/pzbcm_multi_bits_monitor.sv
// Registered multi-bit monitor: sticky error FSM, saturating counter, first-error capture, alarm.
// Define PZBCM_MULTI_BITS_MONITOR_ZERO_CHECK_EN to also flag an all-zero sample (strict one-hot).
`default_nettype none

module pzbcm_multi_bits_monitor
    import pzbcm_multi_bits_monitor_pkg::*;
#(
    parameter int N           = 2,
    parameter int COUNT_WIDTH = 8,
    parameter int THRESHOLD   = 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    input  logic [N-1:0]           i_bits,
    input  logic                   i_clear,
    output logic                   o_detect,
    output logic                   o_error,
    output logic [COUNT_WIDTH-1:0] o_count,
    output logic [N-1:0]           o_first_bits,
    output logic                   o_alarm,
    output logic                   o_saturated
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(calc_count_max(COUNT_WIDTH));
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] ALARM_LVL = COUNT_WIDTH'(THRESHOLD);

`ifdef PZBCM_MULTI_BITS_MONITOR_ZERO_CHECK_EN
    localparam bit ZERO_CHECK = 1'b1;
`else
    localparam bit ZERO_CHECK = 1'b0;
`endif

    pzbcm_multi_bits_monitor_state state_q, state_d;
    logic [COUNT_WIDTH-1:0]        count_q, count_d;
    logic [N-1:0]                  first_q, first_d;
    logic                          detect_q;
    logic                          alarm_q, alarm_d;
    logic                          w_bad;
    logic                          w_err;

    pzbcm_multi_bits_detector #(
        .N             (N),
        .ZERO_IS_ERROR (ZERO_CHECK)
    ) u_detector (
        .i_bits  (i_bits),
        .o_error (w_bad)
    );

    assign w_err = i_valid & w_bad;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        first_d = first_q;

        // Clear takes effect first so a coincident error is seen as a first error.
        if (i_clear) begin
            state_d = CLEAN;
            count_d = '0;
            first_d = '0;
        end

        if (w_err) begin
            case (state_d)
                CLEAN: begin
                    first_d = i_bits;
                    count_d = COUNT_ONE;
                    state_d = (COUNT_ONE == COUNT_MAX) ? SATURATED : ERROR;
                end
                ERROR: begin
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + COUNT_ONE;
                    end
                    if (count_d == COUNT_MAX) begin
                        state_d = SATURATED;
                    end
                end
                SATURATED: begin
                    count_d = count_q;
                end
                default: begin
                    state_d = CLEAN;
                end
            endcase
        end

        alarm_d = (count_d >= ALARM_LVL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= CLEAN;
            count_q  <= '0;
            first_q  <= '0;
            detect_q <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            first_q  <= first_d;
            detect_q <= w_err;
            alarm_q  <= alarm_d;
        end
    end

    assign o_detect     = detect_q;
    assign o_error      = (state_q != CLEAN);
    assign o_saturated  = (state_q == SATURATED);
    assign o_count      = count_q;
    assign o_first_bits = first_q;
    assign o_alarm      = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_pzbcm_multi_bits_monitor.sv
// Self-checking bench for pzbcm_multi_bits_monitor (N=4, COUNT_WIDTH=2, THRESHOLD=2).
`default_nettype none

module tb_pzbcm_multi_bits_monitor;

    localparam int N  = 4;
    localparam int CW = 2;
    localparam int TH = 2;

    typedef struct {
        logic          valid;
        logic [N-1:0]  bits;
        logic          clear;
        logic          det;
        logic          err;
        logic [CW-1:0] cnt;
        logic [N-1:0]  first;
        logic          alarm;
        logic          sat;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          i_valid;
    logic [N-1:0]  i_bits;
    logic          i_clear;
    logic          o_detect;
    logic          o_error;
    logic [CW-1:0] o_count;
    logic [N-1:0]  o_first_bits;
    logic          o_alarm;
    logic          o_saturated;

    int   n_checks;
    int   n_errors;
    vec_t sb[$];
    vec_t tbl[15];
    vec_t hold;

    pzbcm_multi_bits_monitor #(
        .N           (N),
        .COUNT_WIDTH (CW),
        .THRESHOLD   (TH)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (i_valid),
        .i_bits       (i_bits),
        .i_clear      (i_clear),
        .o_detect     (o_detect),
        .o_error      (o_error),
        .o_count      (o_count),
        .o_first_bits (o_first_bits),
        .o_alarm      (o_alarm),
        .o_saturated  (o_saturated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic v, input logic [N-1:0] b, input logic c,
                                input logic d, input logic e, input logic [CW-1:0] n,
                                input logic [N-1:0] f, input logic a, input logic s);
        vec_t r;
        r.valid = v; r.bits = b; r.clear = c;
        r.det = d; r.err = e; r.cnt = n; r.first = f; r.alarm = a; r.sat = s;
        return r;
    endfunction

    task automatic chk1(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_outputs(input string name, input vec_t e);
        chk1({name, ".detect"},    int'(o_detect),     int'(e.det));
        chk1({name, ".error"},     int'(o_error),      int'(e.err));
        chk1({name, ".count"},     int'(o_count),      int'(e.cnt));
        chk1({name, ".first"},     int'(o_first_bits), int'(e.first));
        chk1({name, ".alarm"},     int'(o_alarm),      int'(e.alarm));
        chk1({name, ".saturated"}, int'(o_saturated),  int'(e.sat));
    endtask

    // Drive one sample, queue its expected result, compare once the DUT has registered it.
    task automatic step(input string name, input vec_t v);
        vec_t e;
        @(negedge clk);
        i_valid = v.valid;
        i_bits  = v.bits;
        i_clear = v.clear;
        sb.push_back(v);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check_outputs(name, e);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_bits   = '0;
        i_clear  = 1'b0;

        //            v  bits     clr det err cnt first    alm sat
        tbl[0]  = mk(1, 4'b0001, 0,  0,  0,  0,  4'b0000, 0,  0);
        tbl[1]  = mk(1, 4'b0100, 0,  0,  0,  0,  4'b0000, 0,  0);
        tbl[2]  = mk(1, 4'b1000, 0,  0,  0,  0,  4'b0000, 0,  0);
        tbl[3]  = mk(0, 4'b0000, 0,  0,  0,  0,  4'b0000, 0,  0);
        tbl[4]  = mk(1, 4'b0110, 0,  1,  1,  1,  4'b0110, 0,  0);
        tbl[5]  = mk(1, 4'b0010, 0,  0,  1,  1,  4'b0110, 0,  0);
        tbl[6]  = mk(1, 4'b1100, 0,  1,  1,  2,  4'b0110, 1,  0);
        tbl[7]  = mk(1, 4'b0011, 0,  1,  1,  3,  4'b0110, 1,  1);
        tbl[8]  = mk(1, 4'b1111, 0,  1,  1,  3,  4'b0110, 1,  1);
        tbl[9]  = mk(0, 4'b1111, 0,  0,  1,  3,  4'b0110, 1,  1);
        tbl[10] = mk(1, 4'b1010, 1,  1,  1,  1,  4'b1010, 0,  0);
        tbl[11] = mk(0, 4'b0000, 1,  0,  0,  0,  4'b0000, 0,  0);
`ifdef PZBCM_MULTI_BITS_MONITOR_ZERO_CHECK_EN
        tbl[12] = mk(1, 4'b0000, 0,  1,  1,  1,  4'b0000, 0,  0);
`else
        tbl[12] = mk(1, 4'b0000, 0,  0,  0,  0,  4'b0000, 0,  0);
`endif
        tbl[13] = mk(0, 4'b0000, 1,  0,  0,  0,  4'b0000, 0,  0);
        tbl[14] = mk(1, 4'b0101, 0,  1,  1,  1,  4'b0101, 0,  0);

        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset", mk(0, 4'b0, 0, 0, 0, 0, 4'b0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            step($sformatf("vec%0d", i), tbl[i]);
        end

        // Invalid samples with all bits set must not disturb anything.
        hold = mk(0, 4'b1111, 0, 0, 1, 1, 4'b0101, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step($sformatf("hold%0d", i), hold);
        end

        // Asynchronous reset while in ERROR, checked before any clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", mk(0, 4'b0, 0, 0, 0, 0, 4'b0, 0, 0));
        @(negedge clk);
        rst_n   = 1'b1;
        i_valid = 1'b0;
        i_bits  = '0;
        i_clear = 1'b0;

        // Five back-to-back errors from CLEAN: alarm at 2, saturate at 3, hold at 3.
        step("burst0", mk(1, 4'b0011, 0, 1, 1, 1, 4'b0011, 0, 0));
        step("burst1", mk(1, 4'b0101, 0, 1, 1, 2, 4'b0011, 1, 0));
        step("burst2", mk(1, 4'b0110, 0, 1, 1, 3, 4'b0011, 1, 1));
        step("burst3", mk(1, 4'b1001, 0, 1, 1, 3, 4'b0011, 1, 1));
        step("burst4", mk(1, 4'b1111, 0, 1, 1, 3, 4'b0011, 1, 1));
        step("idle",   mk(0, 4'b0000, 0, 0, 1, 3, 4'b0011, 1, 1));
        step("clear",  mk(0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0));

        @(negedge clk);
        i_valid = 1'b0;
        i_clear = 1'b0;
        chk1("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
